// File: rtl/pe_stream_if.sv
// Stream bundle for pe_stream: input beats (LANES input/weight pairs per
// beat) and the single-word result, both with valid/ready handshakes.
// slave = the PE side, master = the producer/consumer side.
interface pe_stream_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [LANES-1:0][DATA_W-1:0]   in_data;
  logic [LANES-1:0][DATA_W-1:0]   w_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_data;

  modport slave  (input  in_valid, in_data, w_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, w_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/pe_stream.sv
// pe_stream: sequential neuron, out = sat(bias + sum(in_i * w_i)), with
// sign-magnitude operands streamed LANES pairs per beat.
// Optional macro PE_RELU_EN: negative saturated results are emitted as +0.

// One lane: signed product of two sign-magnitude words, zero when inactive.
module pe_lane #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] i_w,
  input  logic              i_act,
  output logic [ACC_W-1:0]  o_prod
);
  localparam int MW = 2*(DATA_W-1);

  logic [MW-1:0]    w_mag;
  logic [ACC_W-1:0] w_ext;
  logic             w_neg;

  assign w_mag  = MW'(i_in[DATA_W-2:0]) * MW'(i_w[DATA_W-2:0]);
  assign w_ext  = {{(ACC_W-MW){1'b0}}, w_mag};
  assign w_neg  = i_in[DATA_W-1] ^ i_w[DATA_W-1];
  // a zero magnitude negates to zero, so negative zero needs no special case
  assign o_prod = !i_act ? '0 : (w_neg ? (~w_ext + 1'b1) : w_ext);
endmodule

module pe_stream #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int MAX_INPUTS = 62,
  parameter int ACC_W      = 24,
  localparam int CNT_W     = $clog2(MAX_INPUTS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_inputs,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  pe_stream_if.slave        bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] MAXV    = ACC_W'(2**(DATA_W-1)-1);
  localparam logic [CNT_W-1:0]        MAX_C   = CNT_W'(MAX_INPUTS);
  localparam logic [CNT_W-1:0]        LANES_C = CNT_W'(LANES);

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [CNT_W-1:0]         r_rem, w_rem_nxt;
  logic [DATA_W-1:0]        r_out;

  logic                     w_fire;
  logic                     w_last;
  logic [CNT_W-1:0]         w_rem_init;
  logic [CNT_W-1:0]         w_step;
  logic [ACC_W-1:0]         w_bias_mag;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic [LANES-1:0]         w_act;
  logic [LANES-1:0][ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;

  // Clamp to +/-(2^(DATA_W-1)-1) and re-encode as sign-magnitude; zero is +0.
  function automatic logic [DATA_W-1:0] sat_sm(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] m;
    logic [DATA_W-1:0]       r;
    m = (a < 0) ? -a : a;
    if (m > MAXV) r = {(a < 0), {(DATA_W-1){1'b1}}};
    else          r = {(a < 0), m[DATA_W-2:0]};
`ifdef PE_RELU_EN
    if (a < 0) r = '0;
`endif
    return r;
  endfunction

  // handshake outputs decode straight from the state register
  assign busy          = (r_state != S_IDLE);
  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_out;

  assign w_fire     = (r_state == S_ACC) && bus.in_valid;
  assign w_rem_init = (n_inputs > MAX_C) ? MAX_C : n_inputs;
  assign w_step     = (r_rem < LANES_C) ? r_rem : LANES_C;
  assign w_last     = (r_rem <= LANES_C);
  assign w_bias_mag = {{(ACC_W-DATA_W+1){1'b0}}, bias[DATA_W-2:0]};
  assign w_bias_ext = bias[DATA_W-1] ? -$signed(w_bias_mag) : $signed(w_bias_mag);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_act[k] = (r_state == S_ACC) && (r_rem > CNT_W'(k));
    pe_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .i_in   (bus.in_data[k]),
      .i_w    (bus.w_data[k]),
      .i_act  (w_act[k]),
      .o_prod (w_prod[k])
    );
  end

  // Adder tree over the lane products (inactive lanes already zeroed).
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) w_sum = w_sum + $signed(w_prod[k]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (w_rem_init == '0) ? S_OUT : S_ACC;
      S_ACC:  if (w_fire && w_last) w_state_nxt = S_OUT;
      S_OUT:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next accumulator / remaining count.
  always_comb begin
    w_acc_nxt = r_acc;
    w_rem_nxt = r_rem;
    if (r_state == S_IDLE && start) begin
      w_acc_nxt = w_bias_ext;
      w_rem_nxt = w_rem_init;
    end else if (w_fire) begin
      w_acc_nxt = r_acc + w_sum;
      w_rem_nxt = r_rem - w_step;
    end
  end

  // Datapath registers; the result word is latched once on entry to OUT so
  // it stays stable however long out_ready is held low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_out <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_rem <= w_rem_nxt;
      if (w_state_nxt == S_OUT && r_state != S_OUT) r_out <= sat_sm(w_acc_nxt);
    end
  end
endmodule
